// File: rtl/button_press_classifier.sv
// Turns debounced press/release pulses into single-click, double-click and
// long-press gesture pulses, with a long_held level and a busy flag.
module button_press_classifier #(
    parameter int LONG_TICKS = 50_000_000,
    parameter int GAP_TICKS  = 25_000_000,
    parameter int CNT_W      = 26
) (
    input  logic clk,
    input  logic reset_n,
    input  logic p_edge,
    input  logic n_edge,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic long_held,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        HOLD   = 3'd2,
        GAP    = 3'd3,
        PRESS2 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] timer_reg;

    // Simultaneous press and release carry no information and are dropped.
    logic press;
    logic release_ev;
    assign press      = p_edge & ~n_edge;
    assign release_ev = n_edge & ~p_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            long_held    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (press) begin
                        state_reg <= PRESS1;
                        timer_reg <= '0;
                        busy      <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (release_ev) begin
                        state_reg <= GAP;
                        timer_reg <= '0;
                    end else if (timer_reg == LONG_LAST) begin
                        state_reg  <= HOLD;
                        timer_reg  <= '0;
                        long_press <= 1'b1;
                        long_held  <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + CNT_W'(1);
                    end
                end
                // HOLD has no timeout, so the timer rests at zero here.
                HOLD: begin
                    if (release_ev) begin
                        state_reg <= IDLE;
                        long_held <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                GAP: begin
                    if (press) begin
                        state_reg <= PRESS2;
                        timer_reg <= '0;
                    end else if (timer_reg == GAP_LAST) begin
                        state_reg    <= IDLE;
                        timer_reg    <= '0;
                        single_click <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + CNT_W'(1);
                    end
                end
                PRESS2: begin
                    if (release_ev) begin
                        state_reg    <= IDLE;
                        timer_reg    <= '0;
                        double_click <= 1'b1;
                        busy         <= 1'b0;
                    end else if (timer_reg == LONG_LAST) begin
                        // First click is reported; the second becomes a long press.
                        state_reg    <= HOLD;
                        timer_reg    <= '0;
                        single_click <= 1'b1;
                        long_press   <= 1'b1;
                        long_held    <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    timer_reg <= '0;
                    long_held <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: directed gesture scenarios plus random
// edge traffic, compared against a timestamp-based gesture model.
module tb_button_press_classifier;

    localparam int LONG = 10;
    localparam int GAP  = 6;

    logic clk;
    logic reset_n;
    logic p_edge;
    logic n_edge;
    logic single_click;
    logic double_click;
    logic long_press;
    logic long_held;
    logic busy;

    int checks = 0;
    int errors = 0;

    // Gesture model: absolute edge count plus timestamps of press/release.
    int t = 0;
    int press_t = 0;
    int rel_t = 0;
    bit pressed = 0;
    bit second = 0;
    bit gap_open = 0;
    bit held = 0;
    bit m_single = 0;
    bit m_double = 0;
    bit m_long = 0;

    button_press_classifier #(
        .LONG_TICKS(LONG),
        .GAP_TICKS (GAP),
        .CNT_W     (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .p_edge      (p_edge),
        .n_edge      (n_edge),
        .single_click(single_click),
        .double_click(double_click),
        .long_press  (long_press),
        .long_held   (long_held),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        pressed = 0; second = 0; gap_open = 0; held = 0;
        m_single = 0; m_double = 0; m_long = 0;
    endtask

    task automatic model_edge(input bit p, input bit n);
        bit ev_p;
        bit ev_n;
        ev_p = p && !n;
        ev_n = n && !p;
        m_single = 0; m_double = 0; m_long = 0;
        if (held) begin
            if (ev_n) held = 0;
        end else if (pressed) begin
            if (ev_n) begin
                pressed = 0;
                if (second) m_double = 1;
                else begin gap_open = 1; rel_t = t; end
            end else if (t - press_t == LONG) begin
                pressed = 0; held = 1; m_long = 1;
                if (second) m_single = 1;
            end
        end else if (gap_open) begin
            if (ev_p) begin
                gap_open = 0; pressed = 1; second = 1; press_t = t;
            end else if (t - rel_t == GAP) begin
                gap_open = 0; m_single = 1;
            end
        end else if (ev_p) begin
            pressed = 1; second = 0; press_t = t;
        end
        t++;
    endtask

    task automatic check_all(input string tag);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {single_click, double_click, long_press, long_held, busy};
        exp = {m_single, m_double, m_long, held, pressed | gap_open | held};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed {sc,dc,lp,lh,busy}=%b expected %b", tag, t, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input bit p, input bit n, input string tag);
        p_edge = p;
        n_edge = n;
        @(posedge clk);
        model_edge(p, n);
        #1;
        p_edge = 1'b0;
        n_edge = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, "idle");
    endtask

    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int dens;
        int r;
        reset_n = 1'b0;
        p_edge  = 1'b0;
        n_edge  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;
        idle(2);

        // 1: short click, then silence -> single_click 6 edges after release
        for (int e = 0; e <= 11; e++) begin
            step(e == 0, e == 4, "s1");
            if (e == 9)  check1("s1_busy9", busy, 1'b1);
            if (e == 10) check1("s1_single10", single_click, 1'b1);
            if (e == 11) check1("s1_busy11", busy, 1'b0);
        end
        idle(3);

        // 2: double click
        for (int e = 0; e <= 10; e++) begin
            step(e == 0 || e == 6, e == 3 || e == 8, "s2");
            if (e == 8) begin
                check1("s2_double8", double_click, 1'b1);
                check1("s2_busy8", busy, 1'b0);
            end
        end
        idle(10);

        // 3: long press held until edge 25
        for (int e = 0; e <= 27; e++) begin
            step(e == 0, e == 25, "s3");
            if (e == 10) check1("s3_long10", long_press, 1'b1);
            if (e == 24) check1("s3_held24", long_held, 1'b1);
            if (e == 25) check1("s3_held25", long_held, 1'b0);
        end
        idle(3);

        // 4: release exactly in the threshold cycle
        for (int e = 0; e <= 17; e++) begin
            step(e == 0, e == 10, "s4");
            if (e == 10) check1("s4_nolong10", long_press, 1'b0);
            if (e == 16) check1("s4_single16", single_click, 1'b1);
        end
        idle(3);

        // 5: click then long-held second press
        for (int e = 0; e <= 17; e++) begin
            step(e == 0 || e == 5, e == 2 || e == 17, "s5");
            if (e == 15) begin
                check1("s5_single15", single_click, 1'b1);
                check1("s5_long15", long_press, 1'b1);
            end
        end
        idle(3);

        // 6: reset mid-gesture, then simultaneous p/n in IDLE
        for (int e = 0; e <= 4; e++) step(e == 0, 1'b0, "s6");
        do_reset("s6_reset");
        idle(20);
        step(1, 1, "s6_both");
        check1("s6_both_busy", busy, 1'b0);
        idle(3);

        // Random traffic in blocks of varying edge density
        for (int blk = 0; blk < 20; blk++) begin
            dens = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 10 : 30);
            for (int i = 0; i < 100; i++) begin
                r = $urandom_range(0, 99);
                if ($urandom_range(0, 399) == 0) do_reset("rnd_reset");
                step(r < dens || r == 99, (r >= dens && r < 2 * dens) || r == 99, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
